// File: rtl/block_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : block_stream_reader
//  Description : Read-side controller for a P-block circular sample RAM.
//                Tracks committed-block occupancy, fetches one packed block
//                at a time, serializes it one sample per valid/ready
//                handshake and releases the RAM slot on the final sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_stream_reader #(
    parameter int P       = 2,
    parameter int NP      = 1024,
    parameter int NB_DATA = 32
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_block_written,
    output logic                      o_ram_enable,
    output logic [$clog2(P)-1:0]      o_read_addr,
    input  logic [NP*NB_DATA-1:0]     i_ram_data,
    output logic [NB_DATA-1:0]        o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_block_released,
    output logic [$clog2(P+1)-1:0]    o_count,
    output logic                      o_overflow
);

    localparam int AW = $clog2(P);
    localparam int CW = $clog2(P + 1);
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(P);
    localparam logic [AW-1:0] PTR_LAST   = AW'(P - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NP*NB_DATA-1:0]  hold_q, hold_d;
    logic                   released_q, released_d;
    logic                   overflow_q, overflow_d;

    // Final handshake of a block; drives both the slot release and the count.
    logic                   release_now;

    // Unpacked view of the holding register; sample 0 sits in the LSBs.
    logic [NB_DATA-1:0]     samples [NP];

    generate
        for (genvar g = 0; g < NP; g++) begin : g_sample
            assign samples[g] = hold_q[g*NB_DATA +: NB_DATA];
        end
    endgenerate

    // Next-state and output decode for the fetch/stream sequencer.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        o_ram_enable = 1'b0;
        o_valid      = 1'b0;
        o_data       = '0;
        o_last       = 1'b0;
        release_now  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Decision uses the registered count only, so a write pulse
                // in this cycle is seen one cycle later.
                if (count_q != '0) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                o_ram_enable = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // RAM data is valid now (one-cycle read latency).
                hold_d  = i_ram_data;
                idx_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                o_valid = 1'b1;
                o_data  = samples[idx_q];
                o_last  = (idx_q == IDX_LAST);
                if (i_ready) begin
                    if (idx_q == IDX_LAST) begin
                        release_now = 1'b1;
                        rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy count, sticky overflow and the delayed release pulse.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        released_d = release_now;

        if (i_block_written && !release_now) begin
            if (count_q == COUNT_FULL) begin
                // Writer outran the reader: saturate and flag it.
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (!i_block_written && release_now) begin
            count_d = count_q - 1'b1;
        end
    end

    // State register; reset abandons any in-flight block with no release.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            released_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            released_q <= released_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_read_addr      = rd_ptr_q;
    assign o_count          = count_q;
    assign o_block_released = released_q;
    assign o_overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_block_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_stream_reader
//  Description : Directed, self-checking bench for block_stream_reader
//                with P=4, NP=4, NB_DATA=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_stream_reader;

    localparam int P  = 4;
    localparam int NP = 4;
    localparam int NB = 8;

    logic              clock           = 1'b0;
    logic              i_reset         = 1'b1;
    logic              i_block_written = 1'b0;
    logic              i_ready         = 1'b0;
    logic [NP*NB-1:0]  i_ram_data      = '0;
    logic              o_ram_enable;
    logic [1:0]        o_read_addr;
    logic [NB-1:0]     o_data;
    logic              o_valid;
    logic              o_last;
    logic              o_block_released;
    logic [2:0]        o_count;
    logic              o_overflow;

    logic [31:0]       mem [4];

    int n_cmp   = 0;
    int n_fail  = 0;
    int rel_cnt = 0;

    typedef struct {
        logic        wr;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs [10];

    block_stream_reader #(
        .P       (P),
        .NP      (NP),
        .NB_DATA (NB)
    ) dut (
        .clock            (clock),
        .i_reset          (i_reset),
        .i_block_written  (i_block_written),
        .o_ram_enable     (o_ram_enable),
        .o_read_addr      (o_read_addr),
        .i_ram_data       (i_ram_data),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_last           (o_last),
        .o_block_released (o_block_released),
        .o_count          (o_count),
        .o_overflow       (o_overflow)
    );

    always #5 clock = ~clock;

    // Synchronous RAM model with one-cycle read latency.
    always @(posedge clock) begin
        if (o_ram_enable) i_ram_data <= mem[o_read_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset         = 1'b1;
        i_block_written = 1'b0;
        i_ready         = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        i_reset = 1'b0;
        tick();
    endtask

    function automatic logic [16:0] mk(input logic v, input logic l, input logic en,
                                       input logic rel, input logic [7:0] d,
                                       input logic [1:0] a, input logic [2:0] c);
        return {v, l, en, rel, d, a, c};
    endfunction

    // Wait for a block to start streaming, then drain it at full rate.
    task automatic stream_block(input logic [1:0] exp_addr, input logic [7:0] base);
        int b;
        b = 0;
        while (!o_valid && b < 12) begin
            tick();
            b++;
        end
        chk("stream_start", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        for (int j = 0; j < NP; j++) begin
            chk($sformatf("stream_data[%0d]", j), {24'd0, o_data}, {24'd0, base + 8'(j + 1)});
            chk($sformatf("stream_last[%0d]", j), {31'd0, o_last}, (j == NP - 1) ? 32'd1 : 32'd0);
            chk("stream_addr", {30'd0, o_read_addr}, {30'd0, exp_addr});
            tick();
        end
        chk("stream_release", {31'd0, o_block_released}, 32'd1);
        if (o_block_released) rel_cnt++;
    endtask

    initial begin
        int b;
        int k;
        int cyc;
        logic [7:0] bp_exp [4];

        for (int a = 0; a < 4; a++) begin
            mem[a] = {8'(a*16 + 4), 8'(a*16 + 3), 8'(a*16 + 2), 8'(a*16 + 1)};
        end

        vecs[0] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 8'h00, 2'd0, 3'd0)};
        vecs[1] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 8'h00, 2'd0, 3'd1)};
        vecs[2] = '{1'b0, 1'b1, mk(0, 0, 1, 0, 8'h00, 2'd0, 3'd1)};
        vecs[3] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 8'h00, 2'd0, 3'd1)};
        vecs[4] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 8'h01, 2'd0, 3'd1)};
        vecs[5] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 8'h02, 2'd0, 3'd1)};
        vecs[6] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 8'h03, 2'd0, 3'd1)};
        vecs[7] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 8'h04, 2'd0, 3'd1)};
        vecs[8] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 8'h00, 2'd1, 3'd0)};
        vecs[9] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 8'h00, 2'd1, 3'd0)};

        // ---------------- reset state ----------------
        #2;
        chk("reset_outputs",
            {15'd0, o_valid, o_last, o_ram_enable, o_block_released, o_data, o_read_addr, o_count},
            32'd0);
        chk("reset_overflow", {31'd0, o_overflow}, 32'd0);
        do_reset();

        // ---------------- single block, cycle-exact ----------------
        for (int i = 0; i < 10; i++) begin
            i_block_written = vecs[i].wr;
            i_ready         = vecs[i].rdy;
            chk($sformatf("vec%0d", i),
                {15'd0, o_valid, o_last, o_ram_enable, o_block_released, o_data, o_read_addr, o_count},
                {15'd0, vecs[i].exp});
            tick();
        end

        // ---------------- backpressure (read pointer now 1) ----------------
        bp_exp[0] = 8'h11; bp_exp[1] = 8'h12; bp_exp[2] = 8'h13; bp_exp[3] = 8'h14;
        i_ready = 1'b0;
        i_block_written = 1'b1;
        tick();
        i_block_written = 1'b0;
        b = 0;
        while (!o_valid && b < 12) begin
            tick();
            b++;
        end
        chk("bp_start", {31'd0, o_valid}, 32'd1);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            i_ready = (cyc % 3 == 0);
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_data", {24'd0, o_data}, {24'd0, bp_exp[k]});
            chk("bp_last", {31'd0, o_last}, (k == 3) ? 32'd1 : 32'd0);
            chk("bp_addr", {30'd0, o_read_addr}, 32'd1);
            if (i_ready && o_valid) k++;
            tick();
            cyc++;
        end
        i_ready = 1'b0;
        chk("bp_handshakes", k, 4);
        chk("bp_release", {31'd0, o_block_released}, 32'd1);
        chk("bp_valid_gap", {31'd0, o_valid}, 32'd0);
        chk("bp_count", {29'd0, o_count}, 32'd0);

        // ---------------- wrap-around ----------------
        do_reset();
        rel_cnt = 0;
        for (int blk = 0; blk < 6; blk++) begin
            i_block_written = 1'b1;
            tick();
            i_block_written = 1'b0;
            stream_block(2'(blk % 4), 8'((blk % 4) * 16));
        end
        chk("wrap_releases", rel_cnt, 6);
        chk("wrap_count", {29'd0, o_count}, 32'd0);

        // ---------------- simultaneous write + release ----------------
        do_reset();
        i_ready = 1'b1;
        i_block_written = 1'b1;
        tick();
        tick();
        i_block_written = 1'b0;
        b = 0;
        while (!(o_valid && o_last) && b < 20) begin
            tick();
            b++;
        end
        chk("simul_last_seen", {31'd0, o_valid & o_last}, 32'd1);
        chk("simul_count_before", {29'd0, o_count}, 32'd2);
        i_block_written = 1'b1;
        tick();
        i_block_written = 1'b0;
        chk("simul_count_after", {29'd0, o_count}, 32'd2);
        chk("simul_release", {31'd0, o_block_released}, 32'd1);
        stream_block(2'd1, 8'h10);
        chk("simul_count_mid", {29'd0, o_count}, 32'd1);
        stream_block(2'd2, 8'h20);
        chk("simul_count_end", {29'd0, o_count}, 32'd0);

        // ---------------- overflow ----------------
        do_reset();
        i_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            i_block_written = 1'b1;
            tick();
            chk($sformatf("ovf_count%0d", n), {29'd0, o_count}, (n < 4) ? 32'(n + 1) : 32'd4);
            chk($sformatf("ovf_flag%0d", n), {31'd0, o_overflow}, (n < 4) ? 32'd0 : 32'd1);
        end
        i_block_written = 1'b0;
        repeat (3) tick();
        chk("ovf_sticky_idle", {31'd0, o_overflow}, 32'd1);
        for (int a = 0; a < 4; a++) begin
            stream_block(2'(a), 8'(a * 16));
            chk("ovf_sticky_drain", {31'd0, o_overflow}, 32'd1);
        end
        chk("ovf_count_drained", {29'd0, o_count}, 32'd0);

        // ---------------- async reset mid-stream ----------------
        do_reset();
        i_ready = 1'b1;
        i_block_written = 1'b1;
        tick();
        i_block_written = 1'b0;
        b = 0;
        while (!o_valid && b < 12) begin
            tick();
            b++;
        end
        tick();
        tick();
        chk("arst_idx2_data", {24'd0, o_data}, 32'h03);
        i_ready = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_outputs",
            {15'd0, o_valid, o_last, o_ram_enable, o_block_released, o_data, o_read_addr, o_count},
            32'd0);
        chk("arst_overflow", {31'd0, o_overflow}, 32'd0);
        #1;
        i_reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("arst_no_release", {31'd0, o_block_released}, 32'd0);
        end
        i_block_written = 1'b1;
        tick();
        i_block_written = 1'b0;
        stream_block(2'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
